// File: rtl/shared_inc_pkg.sv
// Shared definitions for the round-robin incrementer scheduler:
// FSM state type, parameter sanity check and wrapped pointer advance.
package shared_inc_pkg;

  typedef enum logic {
    SI_IDLE = 1'b0,
    SI_HOLD = 1'b1
  } si_state_e;

  function automatic bit nreq_ok(input int n);
    return (n >= 2) && (n <= 16);
  endfunction

  // Advance a requester index by one, wrapping at n (n need not be a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_inc_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping modulo NREQ. Produces any-valid flag, winner index and one-hot grant.
module shared_inc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  win,
  output logic [NREQ-1:0] grant
);

  int idx;

  // Scan from farthest to nearest so the nearest valid index (from rr_ptr) is written last.
  always_comb begin
    any   = 1'b0;
    win   = '0;
    grant = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        any        = 1'b1;
        win        = IDW'(idx);
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_inc_sched.sv
// Shares one WIDTH-bit incrementer between NREQ requesters; the granted operand+1
// is registered with its requester ID and carry and held until consumed.
module shared_inc_sched
  import shared_inc_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [WIDTH-1:0] req_data [NREQ],
  output logic [NREQ-1:0]  req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [IDW-1:0]   resp_id,
  output logic             resp_carry
);

  if (!nreq_ok(NREQ) || WIDTH < 1) begin : g_bad_params
    $error("shared_inc_sched: NREQ must be 2..16 and WIDTH >= 1");
  end

  si_state_e        state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             carry_q, carry_d;

  logic             any;
  logic [IDW-1:0]   win;
  logic [NREQ-1:0]  grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH:0]   sum;

  shared_inc_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any       (any),
    .win       (win),
    .grant     (grant)
  );

  // The single shared adder; its extra MSB is the wrap-to-zero carry.
  assign sum = {1'b0, req_data[win]} + (WIDTH + 1)'(1);

  always_comb begin
    can_accept = !rst && (state_q == SI_IDLE || resp_ready);
    accept     = any && can_accept;
    req_ready  = can_accept ? grant : '0;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    carry_d  = carry_q;
    if (accept) begin
      state_d  = SI_HOLD;
      data_d   = sum[WIDTH-1:0];
      carry_d  = sum[WIDTH];
      id_d     = win;
      rr_ptr_d = IDW'(rr_next(int'(win), NREQ));
    end else if (state_q == SI_HOLD && resp_ready) begin
      state_d = SI_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SI_IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      carry_q  <= carry_d;
    end
  end

  assign resp_valid = (state_q == SI_HOLD);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_carry = carry_q;

endmodule

// File: tb/tb_shared_inc_sched.sv
// Bench for shared_inc_sched: vector table with hand-derived grants feeding a
// result scoreboard (NREQ=4), plus a hand-written sequence on an NREQ=3 instance.
module tb_shared_inc_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NREQ=4 instance
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_data [4];
  logic [3:0] req_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_data;
  logic [1:0] resp_id;
  logic       resp_carry;

  shared_inc_sched #(.NREQ(4), .WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_carry (resp_carry)
  );

  // NREQ=3 instance
  logic       rst3;
  logic [2:0] req_valid3;
  logic [3:0] req_data3 [3];
  logic [2:0] req_ready3;
  logic       resp_valid3;
  logic       resp_ready3;
  logic [3:0] resp_data3;
  logic [1:0] resp_id3;
  logic       resp_carry3;

  shared_inc_sched #(.NREQ(3), .WIDTH(4)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .req_valid  (req_valid3),
    .req_data   (req_data3),
    .req_ready  (req_ready3),
    .resp_valid (resp_valid3),
    .resp_ready (resp_ready3),
    .resp_data  (resp_data3),
    .resp_id    (resp_id3),
    .resp_carry (resp_carry3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [15:0] d;          // {d3,d2,d1,d0}
    logic        rr;
    logic [3:0]  exp_ready;  // hand-derived grant
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
    logic       carry;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [15:0] d,
                              input logic rr, input logic [3:0] er);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.rr = rr; t.exp_ready = er;
    return t;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
  endtask

  task automatic apply4(input vec_t t, input int step);
    res_t r;
    int   w;
    logic [3:0] op;
    @(negedge clk);
    rst        = t.rst;
    req_valid  = t.v;
    resp_ready = t.rr;
    for (int i = 0; i < 4; i++) req_data[i] = t.d[i*4 +: 4];
    #1;
    chk("req_ready", step, 32'(req_ready), 32'(t.exp_ready));
    if (t.rst) begin
      sb.delete();
    end else begin
      if (t.rr && sb.size() > 0) void'(sb.pop_front());
      if (t.exp_ready != 4'b0000) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (t.exp_ready[i]) w = i;
        op = t.d[w*4 +: 4];
        r.data  = op + 4'd1;
        r.id    = 2'(w);
        r.carry = (op == 4'hF);
        sb.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    chk("resp_valid", step, 32'(resp_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      chk("resp_data", step, 32'(resp_data), 32'(sb[0].data));
      chk("resp_id", step, 32'(resp_id), 32'(sb[0].id));
      chk("resp_carry", step, 32'(resp_carry), 32'(sb[0].carry));
    end
    if (t.rst) begin
      chk("rst_data", step, 32'(resp_data), 32'h0);
      chk("rst_id", step, 32'(resp_id), 32'h0);
      chk("rst_carry", step, 32'(resp_carry), 32'h0);
    end
    $display("step %0d: rst=%b valid=%b ready=%b resp_ready=%b -> resp_valid=%b data=%h id=%0d carry=%b",
             step, t.rst, t.v, req_ready, t.rr, resp_valid, resp_data, resp_id, resp_carry);
  endtask

  task automatic step3(input int step, input logic r, input logic [2:0] v, input logic [11:0] d,
                       input logic rr, input logic [2:0] er, input logic ev,
                       input logic [3:0] ed, input logic [1:0] eid, input logic ec);
    @(negedge clk);
    rst3        = r;
    req_valid3  = v;
    resp_ready3 = rr;
    for (int i = 0; i < 3; i++) req_data3[i] = d[i*4 +: 4];
    #1;
    chk("n3_req_ready", step, 32'(req_ready3), 32'(er));
    @(posedge clk);
    #1;
    chk("n3_resp_valid", step, 32'(resp_valid3), 32'(ev));
    if (ev) begin
      chk("n3_resp_data", step, 32'(resp_data3), 32'(ed));
      chk("n3_resp_id", step, 32'(resp_id3), 32'(eid));
      chk("n3_resp_carry", step, 32'(resp_carry3), 32'(ec));
    end
    $display("n3 step %0d: valid=%b ready=%b -> resp_valid=%b data=%h id=%0d carry=%b",
             step, v, req_ready3, resp_valid3, resp_data3, resp_id3, resp_carry3);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    rst3 = 1'b1; req_valid3 = '0; resp_ready3 = 1'b0;
    for (int i = 0; i < 3; i++) req_data3[i] = '0;

    //               rst   valid    data      rdy   exp_ready
    vecs.push_back(mk(1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000)); // reset
    vecs.push_back(mk(1'b1, 4'b0001, 16'h0003, 1'b0, 4'b0000)); // valid during reset ignored
    vecs.push_back(mk(1'b0, 4'b0001, 16'h0003, 1'b0, 4'b0001)); // single request 3 -> 4
    vecs.push_back(mk(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000)); // drain to idle
    vecs.push_back(mk(1'b0, 4'b0100, 16'h0F00, 1'b0, 4'b0100)); // wrap F -> 0, carry
    vecs.push_back(mk(1'b0, 4'b1000, 16'h5000, 1'b1, 4'b1000)); // ptr 3 -> winner 3, ptr back to 0
    vecs.push_back(mk(1'b0, 4'b1111, 16'hA721, 1'b1, 4'b0001)); // fairness 0
    vecs.push_back(mk(1'b0, 4'b1111, 16'hA721, 1'b1, 4'b0010)); // 1
    vecs.push_back(mk(1'b0, 4'b1111, 16'hA721, 1'b1, 4'b0100)); // 2
    vecs.push_back(mk(1'b0, 4'b1111, 16'hA721, 1'b1, 4'b1000)); // 3
    vecs.push_back(mk(1'b0, 4'b1111, 16'hA721, 1'b1, 4'b0001)); // 0 again
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b0, 4'b0000)); // backpressure x3
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b1, 4'b0010)); // above previous winner 0
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b1, 4'b1000)); // 8 -> 9 held
    vecs.push_back(mk(1'b1, 4'b1010, 16'h8040, 1'b0, 4'b0000)); // reset mid-hold
    vecs.push_back(mk(1'b0, 4'b1010, 16'h8040, 1'b0, 4'b0010)); // lowest valid from 0
    vecs.push_back(mk(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000)); // drain

    for (int i = 0; i < vecs.size(); i++) apply4(vecs[i], i);

    // NREQ=3: pointer must wrap from 2 back to 0.  data = {d2,d1,d0}
    step3(0, 1'b1, 3'b000, 12'h000, 1'b0, 3'b000, 1'b0, 4'h0, 2'd0, 1'b0);
    step3(1, 1'b0, 3'b100, 12'h61E, 1'b1, 3'b100, 1'b1, 4'h7, 2'd2, 1'b0);
    step3(2, 1'b0, 3'b111, 12'h61E, 1'b1, 3'b001, 1'b1, 4'hF, 2'd0, 1'b0);
    step3(3, 1'b0, 3'b111, 12'h61E, 1'b1, 3'b010, 1'b1, 4'h2, 2'd1, 1'b0);
    step3(4, 1'b0, 3'b111, 12'h61E, 1'b1, 3'b100, 1'b1, 4'h7, 2'd2, 1'b0);
    step3(5, 1'b0, 3'b111, 12'h61E, 1'b1, 3'b001, 1'b1, 4'hF, 2'd0, 1'b0);
    step3(6, 1'b0, 3'b001, 12'h00F, 1'b1, 3'b001, 1'b1, 4'h0, 2'd0, 1'b1);
    step3(7, 1'b0, 3'b000, 12'h000, 1'b1, 3'b000, 1'b0, 4'h0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_inc_sched.md
# shared_inc_sched

Round-robin scheduler that shares one WIDTH-bit incrementer between NREQ requesters. Each requester presents an operand with a valid/ready handshake. The block grants one requester per cycle, registers operand+1 together with the winner's ID and the carry-out, and holds the result on a single response port until it is consumed. It sits between the requesting procedural blocks and the increment datapath, so no requester ever writes the shared counter directly.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 4, operand/result width (≥1)
- IDW, $clog2(NREQ), requester-ID width (derived; not overridable)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NREQ  per-requester request valid
- req_data  input  NREQ×WIDTH  per-requester operand (unpacked array)
- req_ready  output  NREQ  one-hot-or-zero grant; handshake completes when req_valid[i] & req_ready[i]
- resp_valid  output  1  result held
- resp_ready  input  1  consumer accepts result
- resp_data  output  WIDTH  operand+1 modulo 2^WIDTH
- resp_id  output  IDW  index of granted requester
- resp_carry  output  1  set when operand was all-ones (wrap to 0)

## Operation
- The clock is named clk and the reset is named rst. Reset is synchronous and active-high.
- Two states:
  - IDLE: no result held.
  - HOLD: resp_valid=1.
- can_accept = (state==IDLE) | resp_ready. When rst=1, can_accept=0.
- Grant selection: scan req_valid from rr_ptr upward, wrapping modulo NREQ. The first set bit wins. req_ready[win]=can_accept, and all other req_ready bits are 0.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On accept (any valid & can_accept):
  - resp_data ← req_data[win]+1 (truncated to WIDTH)
  - resp_carry ← &req_data[win]
  - resp_id ← win
  - rr_ptr ← (win+1) mod NREQ
  - state ← HOLD
- HOLD & resp_ready & no valid request: state ← IDLE. resp_data/resp_id/resp_carry keep their last values (don't-care while resp_valid=0).
- HOLD & !resp_ready: outputs stable and all req_ready=0 (backpressure).
- No request pending: rr_ptr unchanged.
- NREQ not a power of two: rr_ptr wraps from NREQ−1 to 0 and never holds an invalid index.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_id 0, resp_carry 0, rr_ptr 0. req_ready is all 0 while rst=1.
- Latency: request accepted in cycle N gives resp_valid=1 in cycle N+1.
- Throughput: one result per cycle when resp_ready is held high. A response is consumed and the next request is accepted in the same cycle.
- Fairness: a continuously-valid requester is granted within NREQ accepts.
- Reset mid-operation: a held result is discarded. The next cycle is IDLE with rr_ptr=0. A request with valid high during the rst cycle is not accepted.
- Simultaneous events: resp_ready and a new request in the same HOLD cycle give a stay in HOLD with the new result. resp_valid never drops for a cycle.

## Structure
- Package shared_inc_pkg:
  - state enum (SI_IDLE, SI_HOLD)
  - parameter-check function for NREQ range
  - helper for the wrapped rr_ptr increment
- Sub-module shared_inc_rr_pick: purely combinational round-robin picker. Inputs req_valid and rr_ptr. Outputs any, win index, and one-hot grant. The top-level holds the state register, result registers, incrementer and pointer.
- The increment is a single WIDTH+1-bit add. resp_carry is the MSB of that add.
- No procedural continuous assignments. All state is updated in one always_ff; grant logic is in always_comb.

## Test plan
- Reset and single request: hold rst for 2 cycles, then req_valid=4'b0001 with req_data[0]=4'h3. Required: req_ready=4'b0001 that cycle; next cycle resp_valid=1, resp_data=4'h4, resp_id=0, resp_carry=0.
- Wrap-around: req_data[2]=4'hF, only requester 2 valid. Required: resp_data=4'h0, resp_carry=1, resp_id=2.
- Round-robin fairness: all four valid continuously, resp_ready=1. Required: resp_id sequence 0,1,2,3,0, with no gaps in resp_valid.
- Backpressure: resp_ready=0 for 3 cycles while requests 1 and 3 are valid. Required: resp outputs stable, req_ready=0; after resp_ready rises, the next grant goes to the requester above the previous winner.
- Reset mid-operation: assert rst while in HOLD with resp_data=4'h9. Required: the next cycle resp_valid=0, resp_data=0; after release the first grant is the lowest valid index from 0.
- Non-power-of-two: NREQ=3, requester 2 granted. Required: rr_ptr returns to 0 and the next grant is requester 0 when all are valid.
